// File: rtl/bcd_to_7seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_7seg_pkg
// Brief    : Segment glyph table, drive constants and polarity helper.
// Revision : 1.0
// ============================================================================
package bcd_to_7seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'b0000000;
  localparam logic [6:0] SEG_ALL = 7'b1111111;

  // Active-high gfedcba glyphs; entry N is the pattern for input code N.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b1110001,  // F
    7'b1111001,  // E
    7'b1011110,  // d
    7'b0111001,  // C
    7'b1111100,  // b
    7'b1110111,  // A
    7'b1101111,  // 9
    7'b1111111,  // 8
    7'b0000111,  // 7
    7'b1111101,  // 6
    7'b1101101,  // 5
    7'b1100110,  // 4
    7'b1001111,  // 3
    7'b1011011,  // 2
    7'b0000110,  // 1
    7'b0111111   // 0
  };

  // Converts an active-high {dp, seg} drive word to the pin polarity.
  function automatic logic [7:0] apply_polarity(input logic [7:0] drive,
                                                input bit         active_low);
    return active_low ? ~drive : drive;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_to_7seg_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg_decode_comb
// Brief    : Combinational 4-bit code to active-high segment pattern lookup.
// Revision : 1.0
// ============================================================================
module seg_decode_comb
  import bcd_to_7seg_pkg::*;
#(
  parameter bit HEX_EN = 1'b0
) (
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o,
  output logic       invalid_o
);

  logic above_nine;

  always_comb begin
    above_nine = (bcd_i > 4'd9);
    invalid_o  = above_nine && !HEX_EN;
    seg_o      = invalid_o ? SEG_OFF : SEG_TABLE[bcd_i];
  end

endmodule
`default_nettype wire

// File: rtl/bcd_to_7seg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_to_7seg
// Brief    : Registered one-digit BCD/hex to seven-segment driver with
//            lamp test, blanking and leading-zero ripple blanking.
// Revision : 1.0
// ============================================================================
module bcd_to_7seg
  import bcd_to_7seg_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0,
  parameter bit HEX_EN     = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bcd,
  input  logic       dp_in,
  input  logic       blank,
  input  logic       lamp_test,
  input  logic       rbi,
  output logic [6:0] seg,
  output logic       dp,
  output logic       invalid,
  output logic       rbo
);

  localparam logic [7:0] RST_DRIVE = apply_polarity({1'b0, SEG_OFF}, ACTIVE_LOW);

  logic [6:0] dec_seg;
  logic       dec_invalid;
  logic       is_zero;

  logic [6:0] seg_d;
  logic       dp_d;
  logic       invalid_d;
  logic [7:0] drive_d;

  logic [6:0] seg_q;
  logic       dp_q;
  logic       invalid_q;

  seg_decode_comb #(
    .HEX_EN (HEX_EN)
  ) u_decode (
    .bcd_i     (bcd),
    .seg_o     (dec_seg),
    .invalid_o (dec_invalid)
  );

  assign is_zero = (bcd == 4'd0);

  // Unregistered so a chain of digits resolves leading zeros within one cycle.
  assign rbo = rbi & is_zero & ~lamp_test & ~blank;

  always_comb begin
    seg_d     = dec_seg;
    dp_d      = dp_in;
    invalid_d = dec_invalid;
    if (lamp_test) begin
      seg_d     = SEG_ALL;
      dp_d      = 1'b1;
      invalid_d = 1'b0;
    end else if (blank) begin
      seg_d     = SEG_OFF;
      dp_d      = 1'b0;
      invalid_d = 1'b0;
    end else if (rbi && is_zero) begin
      seg_d     = SEG_OFF;
      invalid_d = 1'b0;
    end
    drive_d = apply_polarity({dp_d, seg_d}, ACTIVE_LOW);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_q      <= RST_DRIVE[7];
      seg_q     <= RST_DRIVE[6:0];
      invalid_q <= 1'b0;
    end else begin
      dp_q      <= drive_d[7];
      seg_q     <= drive_d[6:0];
      invalid_q <= invalid_d;
    end
  end

  assign seg     = seg_q;
  assign dp      = dp_q;
  assign invalid = invalid_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_7seg.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_to_7seg
// Brief    : Directed and random checks of three parameterisations against
//            a rule-based model of the digit driver.
// Revision : 1.0
// ============================================================================
module tb_bcd_to_7seg;

  localparam logic [6:0] GLYPH [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] bcd = 4'd0;
  logic       dp_in = 1'b0;
  logic       blank = 1'b0;
  logic       lamp_test = 1'b0;
  logic       rbi = 1'b0;

  logic [6:0] seg_a, seg_b, seg_c;
  logic       dp_a, dp_b, dp_c;
  logic       inv_a, inv_b, inv_c;
  logic       rbo_a, rbo_b, rbo_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // a: BCD only, active high; b: hex, active high; c: hex, active low
  bcd_to_7seg #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b0)) u_dut_a (
    .clk(clk), .rst(rst), .bcd(bcd), .dp_in(dp_in), .blank(blank),
    .lamp_test(lamp_test), .rbi(rbi), .seg(seg_a), .dp(dp_a),
    .invalid(inv_a), .rbo(rbo_a));
  bcd_to_7seg #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .bcd(bcd), .dp_in(dp_in), .blank(blank),
    .lamp_test(lamp_test), .rbi(rbi), .seg(seg_b), .dp(dp_b),
    .invalid(inv_b), .rbo(rbo_b));
  bcd_to_7seg #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b1)) u_dut_c (
    .clk(clk), .rst(rst), .bcd(bcd), .dp_in(dp_in), .blank(blank),
    .lamp_test(lamp_test), .rbi(rbi), .seg(seg_c), .dp(dp_c),
    .invalid(inv_c), .rbo(rbo_c));

  // Returns {invalid, dp, seg} as seen on the pins after one clock.
  function automatic logic [8:0] model(input logic [3:0] d, input logic dpi,
                                       input logic bl, input logic lt,
                                       input logic rb, input bit hex,
                                       input bit al);
    logic [6:0] s;
    logic       p;
    logic       inv;
    inv = 1'b0;
    if (lt) begin
      s = 7'h7F; p = 1'b1;
    end else if (bl) begin
      s = 7'h00; p = 1'b0;
    end else if (rb && d == 4'd0) begin
      s = 7'h00; p = dpi;
    end else if (d > 4'd9 && !hex) begin
      s = 7'h00; p = dpi; inv = 1'b1;
    end else begin
      s = GLYPH[d]; p = dpi;
    end
    if (al) begin
      s = ~s; p = ~p;
    end
    return {inv, p, s};
  endfunction

  function automatic logic [8:0] reset_model(input bit al);
    return al ? 9'b0_1_1111111 : 9'b0_0_0000000;
  endfunction

  task automatic check(input string tag, input logic [8:0] obs,
                       input logic [8:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag, input logic [8:0] ea,
                            input logic [8:0] eb, input logic [8:0] ec);
    check({tag, "_a"}, {inv_a, dp_a, seg_a}, ea);
    check({tag, "_b"}, {inv_b, dp_b, seg_b}, eb);
    check({tag, "_c"}, {inv_c, dp_c, seg_c}, ec);
  endtask

  // Applies one input set, checks ripple-out combinationally, then the
  // registered outputs just after the next rising edge.
  task automatic step(input logic [3:0] d, input logic dpi, input logic bl,
                      input logic lt, input logic rb, input string tag);
    logic [8:0] ea, eb, ec;
    logic       erbo;
    bcd = d; dp_in = dpi; blank = bl; lamp_test = lt; rbi = rb;
    ea   = model(d, dpi, bl, lt, rb, 1'b0, 1'b0);
    eb   = model(d, dpi, bl, lt, rb, 1'b1, 1'b0);
    ec   = model(d, dpi, bl, lt, rb, 1'b1, 1'b1);
    erbo = rb && (d == 4'd0) && !lt && !bl;
    #1;
    check({tag, "_rbo"}, {6'd0, rbo_a, rbo_b, rbo_c}, {6'd0, erbo, erbo, erbo});
    @(posedge clk);
    #1;
    check_regs(tag, ea, eb, ec);
  endtask

  initial begin
    logic [3:0] rd;
    #1 rst = 1'b1;
    #1;
    check_regs("reset_async", reset_model(1'b0), reset_model(1'b0), reset_model(1'b1));
    @(posedge clk);
    #1;
    check_regs("reset_held", reset_model(1'b0), reset_model(1'b0), reset_model(1'b1));
    rst = 1'b0;

    for (int i = 0; i < 16; i++)
      step(4'(i), 1'b0, 1'b0, 1'b0, 1'b0, $sformatf("sweep%0d", i));

    step(4'd11, 1'b1, 1'b0, 1'b0, 1'b0, "hex11_dp");
    step(4'd3, 1'b0, 1'b1, 1'b1, 1'b0, "lamp_over_blank");
    step(4'd3, 1'b0, 1'b1, 1'b0, 1'b0, "blank");
    step(4'd0, 1'b1, 1'b0, 1'b0, 1'b1, "ripple_zero");
    step(4'd5, 1'b0, 1'b0, 1'b0, 1'b1, "ripple_five");
    step(4'd0, 1'b1, 1'b1, 1'b0, 1'b1, "ripple_blanked");
    step(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, "b2b_7");
    step(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, "b2b_1");
    step(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, "b2b_4");

    step(4'd8, 1'b1, 1'b0, 1'b0, 1'b0, "pre_reset8");
    rst = 1'b1;
    #1;
    check_regs("reset_mid", reset_model(1'b0), reset_model(1'b0), reset_model(1'b1));
    @(posedge clk);
    #1;
    check_regs("reset_mid_held", reset_model(1'b0), reset_model(1'b0), reset_model(1'b1));
    rst = 1'b0;
    step(4'd8, 1'b1, 1'b0, 1'b0, 1'b0, "post_reset8");

    for (int i = 0; i < 300; i++) begin
      rd = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) rd = 4'd0;
      step(rd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
           $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_to_7seg.md
Name: bcd_to_7seg

Overview:
Registered BCD-to-seven-segment decoder for one display digit. It maps a 4-bit BCD digit to segment drive signals, with blanking, lamp test, decimal point and leading-zero ripple blanking. It sits between the digit-producing datapath (counters, BCD converters) and the display pin drivers. Several instances can be chained for multi-digit displays.

Parameters:
- ACTIVE_LOW, 0, 1 inverts seg and dp at the output register (common-anode display); invalid and rbo are never inverted.
- HEX_EN, 0, 1 decodes inputs 10-15 as A,b,C,d,E,F; 0 treats them as invalid.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- bcd  in  4  digit to display
- dp_in  in  1  decimal point request
- blank  in  1  force all segments and dp off
- lamp_test  in  1  force all segments and dp on
- rbi  in  1  ripple-blank in; blank this digit if it is zero
- seg  out  7  segment drive, seg[0]=a, seg[1]=b ... seg[6]=g
- dp  out  1  decimal point drive
- invalid  out  1  registered flag: bcd>9 with HEX_EN=0
- rbo  out  1  ripple-blank out; this digit was zero-blanked (combinational)

Behaviour:
- Reset (async, rst=1): seg = all off, dp off (0 if ACTIVE_LOW=0, all 1s if ACTIVE_LOW=1), invalid=0. These are held while rst=1.
- Latency: seg, dp and invalid update on the first rising clk edge after the inputs change. There are no bubbles, and one new input is accepted every cycle.
- Active-high segment codes (gfedcba):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
- HEX_EN=1 codes:
  - A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001
- HEX_EN=0 and bcd in 10..15: seg all off, dp follows dp_in, invalid=1. In every other case invalid=0.
- Priority, highest first:
  1. lamp_test: seg=1111111, dp=1, invalid=0.
  2. blank: seg=0, dp=0, invalid=0.
  3. Ripple blank: rbi=1 and bcd=0 gives seg=0, dp=dp_in.
  4. Normal decode: dp=dp_in.
- rbo = rbi & (bcd==0) & ~lamp_test & ~blank. It is combinational and not registered, so a chain settles in one cycle.
- ACTIVE_LOW inversion is applied after priority resolution, only to seg and dp.
- Reset deassertion takes effect at the next rising edge.
- Reset asserted mid-operation clears the outputs immediately, without waiting for clk.
- X-free: all 16 input codes decode deterministically.

Decomposition:
- Package bcd_to_7seg_pkg holds:
  - SEG_OFF and SEG_ALL localparams
  - the 16-entry segment constant table (digits and hex letters)
  - a function to apply polarity
- Sub-module seg_decode_comb: purely combinational 4-bit to 7-bit lookup, taking HEX_EN, outputting seg and invalid.
- The top level holds priority muxing, ripple logic, polarity handling and the output registers.

Test Plan:
- Reset: assert rst mid-run with bcd=8 -> seg=0000000, dp=0, invalid=0 immediately, without a clk edge. ACTIVE_LOW=1 -> seg=1111111, dp=1.
- Sweep bcd 0..9 one per cycle, controls low -> seg matches the table one cycle later (e.g. 2 -> 1011011, 9 -> 1101111), invalid=0.
- bcd=10..15, HEX_EN=0 -> seg=0000000, invalid=1. HEX_EN=1, bcd=11 -> seg=1111100, invalid=0.
- lamp_test=1 with blank=1, bcd=3 -> seg=1111111, dp=1. Then lamp_test=0 -> seg=0000000, dp=0.
- rbi=1, bcd=0, dp_in=1 -> seg=0000000, dp=1, rbo=1 in the same cycle. rbi=1, bcd=5 -> seg=1101101, rbo=0.
- Back-to-back inputs 7,1,4 on consecutive edges -> seg = 0000111, 0000110, 1100110 on the next three edges.
